// File: rtl/fir_filter_ppg.sv
// 16-tap direct-form FIR low-pass filter for one PPG channel: 8-bit unsigned in, 20-bit raw gain-156 out.
// Optional build macro FIR_IN_VALID_EN adds an in_valid strobe that gates the delay-line shift.
module fir_filter_ppg #(
    parameter int TAPS   = 16,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 20,
    parameter logic [TAPS*COEF_W-1:0] COEFFS = {
        8'd1,  8'd2,  8'd4,  8'd7,  8'd11, 8'd15, 8'd18, 8'd20,
        8'd20, 8'd18, 8'd15, 8'd11, 8'd7,  8'd4,  8'd2,  8'd1
    }
) (
    input  logic              CLK_Filter,
    input  logic              rst_n,
`ifdef FIR_IN_VALID_EN
    input  logic              in_valid,
`endif
    input  logic [DATA_W-1:0] ADC_Value,
    output logic [OUT_W-1:0]  Out_Filtered
);

    logic [TAPS-1:0][DATA_W-1:0] dly_q;
    logic [TAPS-1:0][DATA_W-1:0] dly_d;
    logic [OUT_W-1:0]            out_q;
    logic [OUT_W-1:0]            out_d;
    logic                        accept_s;
    logic [OUT_W-1:0]            sum_s;

    // Coefficient c_idx, with c0 held in the least-significant byte of COEFFS.
    function automatic logic [COEF_W-1:0] coef_at(input int idx);
        return COEFFS[idx*COEF_W +: COEF_W];
    endfunction

    // Sample-accept qualifier: every edge, or only strobed edges when the strobe exists.
`ifdef FIR_IN_VALID_EN
    assign accept_s = in_valid;
`else
    assign accept_s = 1'b1;
`endif

    // Delay-line next state: shift in the new sample or hold the current history.
    always_comb begin
        dly_d = dly_q;
        if (accept_s) begin
            dly_d[0] = ADC_Value;
            for (int i = 1; i < TAPS; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end else begin
            dly_d = dly_q;
        end
    end

    // Full-width multiply-accumulate over the pre-edge history; 255*156 fits in OUT_W.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_s = sum_s + (OUT_W'(dly_q[i]) * OUT_W'(coef_at(i)));
        end
        out_d = sum_s;
    end

    // Delay-line and output registers; reset discards all history immediately.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
            out_q <= '0;
        end else begin
            dly_q <= dly_d;
            out_q <= out_d;
        end
    end

    assign Out_Filtered = out_q;

endmodule

// File: tb/tb_fir_filter_ppg.sv
// Self-checking bench for fir_filter_ppg: constant vector tables plus a convolution scoreboard.
// Also covers the in_valid hold behaviour when built with FIR_IN_VALID_EN.
module tb_fir_filter_ppg;

    logic        CLK_Filter;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  ADC_Value;
    logic [19:0] Out_Filtered;

    int n_checks;
    int n_errors;
    int mdl [16];
    int cf  [16];
    int sb_q [$];
    logic [19:0] last_out;

    typedef struct {
        logic [7:0] adc;
        int         exp_out;
    } vec_t;

    vec_t imp_tbl [18];
    vec_t stair_tbl [5];

    fir_filter_ppg dut (
        .CLK_Filter   (CLK_Filter),
        .rst_n        (rst_n),
`ifdef FIR_IN_VALID_EN
        .in_valid     (in_valid),
`endif
        .ADC_Value    (ADC_Value),
        .Out_Filtered (Out_Filtered)
    );

    initial CLK_Filter = 1'b0;
    always #5 CLK_Filter = ~CLK_Filter;

    task automatic check(input string name, input logic [19:0] act, input int exp_v);
        n_checks++;
        if (act !== 20'(exp_v)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // One edge: predict output from the pre-edge model, drive, clock, compare.
    task automatic step(input logic [7:0] adc, input logic vld, input string name);
        int acc;
        int got_exp;
        logic shift_en;
        ADC_Value = adc;
        in_valid  = vld;
`ifdef FIR_IN_VALID_EN
        shift_en = vld;
`else
        shift_en = 1'b1;
`endif
        acc = 0;
        for (int i = 0; i < 16; i++) acc += cf[i] * mdl[i];
        sb_q.push_back(acc);
        if (shift_en) begin
            for (int i = 15; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = int'(adc);
        end
        @(posedge CLK_Filter);
        #1;
        got_exp = sb_q.pop_front();
        check(name, Out_Filtered, got_exp);
        last_out = Out_Filtered;
        @(negedge CLK_Filter);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", Out_Filtered, 0);
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        sb_q.delete();
        @(negedge CLK_Filter);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        ADC_Value = 8'd0;
        cf = '{1, 2, 4, 7, 11, 15, 18, 20, 20, 18, 15, 11, 7, 4, 2, 1};
        for (int i = 0; i < 16; i++) mdl[i] = 0;

        imp_tbl[0] = '{8'd1, 0};
        imp_tbl[1]  = '{8'd0, 1};  imp_tbl[2]  = '{8'd0, 2};  imp_tbl[3]  = '{8'd0, 4};
        imp_tbl[4]  = '{8'd0, 7};  imp_tbl[5]  = '{8'd0, 11}; imp_tbl[6]  = '{8'd0, 15};
        imp_tbl[7]  = '{8'd0, 18}; imp_tbl[8]  = '{8'd0, 20}; imp_tbl[9]  = '{8'd0, 20};
        imp_tbl[10] = '{8'd0, 18}; imp_tbl[11] = '{8'd0, 15}; imp_tbl[12] = '{8'd0, 11};
        imp_tbl[13] = '{8'd0, 7};  imp_tbl[14] = '{8'd0, 4};  imp_tbl[15] = '{8'd0, 2};
        imp_tbl[16] = '{8'd0, 1};  imp_tbl[17] = '{8'd0, 0};

        stair_tbl[0] = '{8'd5,  0};
        stair_tbl[1] = '{8'd10, 5};
        stair_tbl[2] = '{8'd12, 20};
        stair_tbl[3] = '{8'd15, 52};
        stair_tbl[4] = '{8'd16, 114};

        #2;
        check("reset_initial", Out_Filtered, 0);
        @(negedge CLK_Filter);
        rst_n = 1'b1;

        // Impulse response
        for (int k = 0; k < 18; k++) begin
            step(imp_tbl[k].adc, 1'b1, "impulse_sb");
            check($sformatf("impulse_%0d", k), last_out, imp_tbl[k].exp_out);
        end

        // Step of 5 from reset release
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            step(8'd5, 1'b1, "step_sb");
            if (k == 2) check("step_first", last_out, 5);
            if (k == 3) check("step_second", last_out, 15);
            if (k == 5) check("step_fourth", last_out, 70);
            if (k == 17) check("step_settle", last_out, 780);
        end
        check("step_steady", last_out, 780);

        // Asynchronous reset mid-stream, then history must be gone
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", Out_Filtered, 0);
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        sb_q.delete();
        @(negedge CLK_Filter);
        check("reset_held_over_edge", Out_Filtered, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(8'd0, 1'b1, "post_reset_zero");
        check("post_reset_clear", last_out, 0);

        // Full scale
        apply_reset();
        for (int k = 0; k < 18; k++) step(8'd255, 1'b1, "fullscale_sb");
        check("fullscale_steady", last_out, 39780);

        // Staircase then hold 16
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(stair_tbl[k].adc, 1'b1, "stair_sb");
            check($sformatf("stair_%0d", k), last_out, stair_tbl[k].exp_out);
        end
        for (int k = 0; k < 17; k++) step(8'd16, 1'b1, "stair_hold_sb");
        check("stair_steady", last_out, 2496);

        // Random samples against the scoreboard
        for (int k = 0; k < 40; k++) step(8'($urandom_range(0, 255)), 1'b1, "random_sb");

`ifdef FIR_IN_VALID_EN
        // Strobe low for three edges mid-ramp: output freezes, then the ramp resumes
        begin
            logic [19:0] frozen;
            apply_reset();
            for (int k = 0; k < 6; k++) step(8'd3, 1'b1, "valid_ramp_sb");
            step(8'd99, 1'b0, "valid_hold_sb");
            frozen = last_out;
            step(8'd99, 1'b0, "valid_hold_sb");
            check("valid_frozen_1", last_out, int'(frozen));
            step(8'd99, 1'b0, "valid_hold_sb");
            check("valid_frozen_2", last_out, int'(frozen));
            step(8'd3, 1'b1, "valid_resume_sb");
            step(8'd3, 1'b1, "valid_resume_sb");
            check("valid_resume", last_out, 3 * (1 + 2 + 4 + 7 + 11 + 15 + 18));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
